// File: rtl/jk_arb_pkg.sv
// Shared definitions for the JK command arbiter: op encodings and sequencer states.
// The op code doubles as {J,K} for the addressed flop.
package jk_arb_pkg;

  localparam logic [1:0] OP_HOLD   = 2'b00;
  localparam logic [1:0] OP_RESET  = 2'b01;
  localparam logic [1:0] OP_SET    = 2'b10;
  localparam logic [1:0] OP_TOGGLE = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_APPLY  = 2'd1,
    ST_REPORT = 2'd2
  } arb_state_e;

endpackage

// File: rtl/jk_ff_cell.sv
// One JK flip-flop with a clock enable and an asynchronous active-low clear.
module jk_ff_cell (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic j,
  input  logic k,
  output logic q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= 1'b0;
    end else if (en) begin
      case ({j, k})
        2'b01:   q <= 1'b0;
        2'b10:   q <= 1'b1;
        2'b11:   q <= ~q;
        default: q <= q;
      endcase
    end
  end

endmodule

// File: rtl/jk_cmd_arbiter.sv
// Arbiter/sequencer owning a bank of NFF JK flops shared by NREQ requesters.
// Build option JK_ARB_RR_EN selects round-robin priority; otherwise lowest index wins.
module jk_cmd_arbiter
  import jk_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int NFF  = 8,
  parameter int IDXW = $clog2(NFF)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [2*NREQ-1:0]        req_op,
  input  logic [IDXW*NREQ-1:0]     req_idx,
  output logic [NREQ-1:0]          req_ready,
  output logic [NFF-1:0]           q,
  output logic                     done_valid,
  output logic [$clog2(NREQ)-1:0]  done_id,
  output logic                     done_q,
  output logic                     done_err,
  output logic [1:0]               dbg_state
);

  localparam int IDW = $clog2(NREQ);

  arb_state_e       state, state_nxt;
  logic [1:0]       op_r;
  logic [IDXW-1:0]  idx_r;
  logic [IDW-1:0]   id_r;
  logic             err_r;
  logic             win_any;
  logic [IDW-1:0]   win_id;
  logic [1:0]       sel_op;
  logic [IDXW-1:0]  sel_idx;
  logic             hs;
  logic             q_sel;
  logic [NFF-1:0]   ff_en;

`ifdef JK_ARB_RR_EN
  logic [IDW-1:0] last_grant;
  int             c;

  // Search begins one past the previous winner and wraps.
  always_comb begin
    win_any = 1'b0;
    win_id  = '0;
    c       = 0;
    for (int k = 1; k <= NREQ; k++) begin
      c = (int'(last_grant) + k) % NREQ;
      if (!win_any && req_valid[c]) begin
        win_any = 1'b1;
        win_id  = IDW'(c);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant <= IDW'(NREQ - 1);
    end else if (hs) begin
      last_grant <= win_id;
    end
  end
`else
  always_comb begin
    win_any = 1'b0;
    win_id  = '0;
    for (int r = NREQ - 1; r >= 0; r--) begin
      if (req_valid[r]) begin
        win_any = 1'b1;
        win_id  = IDW'(r);
      end
    end
  end
`endif

  // Handshake: a command transfers on a cycle where req_valid[r] & req_ready[r];
  // ready goes only to the current winner, only in IDLE and never while reset is low.
  always_comb begin
    req_ready = '0;
    if (state == ST_IDLE && reset && win_any) req_ready[win_id] = 1'b1;
  end

  assign hs      = |(req_valid & req_ready);
  assign sel_op  = req_op[2*int'(win_id) +: 2];
  assign sel_idx = req_idx[IDXW*int'(win_id) +: IDXW];

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (hs) state_nxt = ST_APPLY;
      ST_APPLY:  state_nxt = ST_REPORT;
      ST_REPORT: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      op_r  <= OP_HOLD;
      idx_r <= '0;
      id_r  <= '0;
      err_r <= 1'b0;
    end else begin
      state <= state_nxt;
      if (hs) begin
        op_r  <= sel_op;
        idx_r <= sel_idx;
        id_r  <= win_id;
        err_r <= (int'(sel_idx) >= NFF);
      end
    end
  end

  // Out-of-range targets enable nothing, which is the same as a hold.
  always_comb begin
    ff_en = '0;
    q_sel = 1'b0;
    for (int i = 0; i < NFF; i++) begin
      if (int'(idx_r) == i) begin
        ff_en[i] = (state == ST_APPLY) && !err_r;
        q_sel    = q[i];
      end
    end
  end

  for (genvar i = 0; i < NFF; i++) begin : g_ff
    jk_ff_cell u_ff (
      .clk   (clk),
      .rst_n (reset),
      .en    (ff_en[i]),
      .j     (op_r[1]),
      .k     (op_r[0]),
      .q     (q[i])
    );
  end

  assign done_valid = (state == ST_REPORT);
  assign done_id    = done_valid ? id_r : '0;
  assign done_err   = done_valid && err_r;
  assign done_q     = done_valid && !err_r && q_sel;
  assign dbg_state  = state;

endmodule

// File: tb/tb_jk_cmd_arbiter.sv
// Self-checking bench for jk_cmd_arbiter: directed table, corner sequences, random vs model.
// Follows the build's JK_ARB_RR_EN setting for expected grant order.
module tb_jk_cmd_arbiter;

  localparam int NREQ = 4;
  localparam int NFF  = 8;
  localparam int IDXW = 3;

  localparam logic [1:0] HOLD = 2'b00, RST = 2'b01, SET = 2'b10, TOG = 2'b11;

  logic              clk, reset;
  logic [NREQ-1:0]   req_valid, req_ready;
  logic [2*NREQ-1:0] req_op;
  logic [IDXW*NREQ-1:0] req_idx;
  logic [NFF-1:0]    q;
  logic              done_valid, done_q, done_err;
  logic [1:0]        done_id, dbg_state;

  logic [NREQ-1:0]   v6, ready6;
  logic [2*NREQ-1:0] op6;
  logic [3*NREQ-1:0] idx6;
  logic [5:0]        q6;
  logic              done6_valid, done6_q, done6_err;
  logic [1:0]        done6_id, dbg6_state;

  jk_cmd_arbiter #(.NREQ(NREQ), .NFF(NFF), .IDXW(IDXW)) u_dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_op(req_op), .req_idx(req_idx),
    .req_ready(req_ready), .q(q), .done_valid(done_valid), .done_id(done_id),
    .done_q(done_q), .done_err(done_err), .dbg_state(dbg_state)
  );

  jk_cmd_arbiter #(.NREQ(NREQ), .NFF(6), .IDXW(3)) u_dut6 (
    .clk(clk), .reset(reset), .req_valid(v6), .req_op(op6), .req_idx(idx6),
    .req_ready(ready6), .q(q6), .done_valid(done6_valid), .done_id(done6_id),
    .done_q(done6_q), .done_err(done6_err), .dbg_state(dbg6_state)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // requester intent and reference model of the flop bank
  bit         p_valid[NREQ];
  logic [1:0] p_op[NREQ];
  logic [2:0] p_idx[NREQ];
  bit         m_q[NFF];
  int         m_last;
  logic [2:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive();
    for (int r = 0; r < NREQ; r++) begin
      req_valid[r]         = p_valid[r];
      req_op[2*r +: 2]     = p_op[r];
      req_idx[IDXW*r +: IDXW] = p_idx[r];
    end
  endtask

  task automatic clear_all();
    for (int r = 0; r < NREQ; r++) begin
      p_valid[r] = 1'b0;
      p_op[r]    = HOLD;
      p_idx[r]   = '0;
    end
    for (int i = 0; i < NFF; i++) m_q[i] = 1'b0;
    m_last = NREQ - 1;
    exp_q.delete();
    drive();
  endtask

  function automatic int model_winner();
    int w;
    w = -1;
`ifdef JK_ARB_RR_EN
    for (int k = 1; k <= NREQ; k++)
      if (w < 0 && p_valid[(m_last + k) % NREQ]) w = (m_last + k) % NREQ;
`else
    for (int r = 0; r < NREQ; r++)
      if (w < 0 && p_valid[r]) w = r;
`endif
    return w;
  endfunction

  function automatic logic [NFF-1:0] model_q_vec();
    logic [NFF-1:0] v;
    for (int i = 0; i < NFF; i++) v[i] = m_q[i];
    return v;
  endfunction

  task automatic model_apply(input int w);
    case (p_op[w])
      RST:     m_q[p_idx[w]] = 1'b0;
      SET:     m_q[p_idx[w]] = 1'b1;
      TOG:     m_q[p_idx[w]] = ~m_q[p_idx[w]];
      default: ;
    endcase
    m_last = w;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    clear_all();
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // One arbitration slot; starts and ends on a falling edge with the DUT idle.
  task automatic run_slot(output int w, output logic [1:0] got_id, output logic got_dq);
    logic [3:0] exp_rdy;
    logic [2:0] e;
    drive();
    w = model_winner();
    exp_rdy = (w >= 0) ? 4'(1 << w) : 4'b0;
    got_id = '0;
    got_dq = 1'b0;
    #1;
    check("ready_idle", req_ready, exp_rdy);
    @(posedge clk); @(negedge clk);
    if (w < 0) begin
      check("no_req_done", done_valid, 0);
      return;
    end
    check("ready_apply", req_ready, 0);
    check("done_apply", done_valid, 0);
    model_apply(w);
    exp_q.push_back({w[1:0], m_q[p_idx[w]]});
    @(posedge clk); @(negedge clk);
    check("q", q, model_q_vec());
    check("done_valid", done_valid, 1);
    e = exp_q.pop_front();
    check("done_id", done_id, e[2:1]);
    check("done_q", done_q, e[0]);
    check("done_err", done_err, 0);
    got_id = done_id;
    got_dq = done_q;
    @(posedge clk); @(negedge clk);
    check("done_drop", done_valid, 0);
  endtask

  task automatic slot6(input logic [2:0] idx, input logic exp_err, input logic exp_dq,
                       input logic [5:0] exp_q6);
    v6 = 4'b0100;
    op6[5:4] = SET;
    idx6[8:6] = idx;
    #1;
    check("ready6", ready6, 4'b0100);
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    check("done6_valid", done6_valid, 1);
    check("done6_id", done6_id, 2);
    check("done6_err", done6_err, exp_err);
    check("done6_q", done6_q, exp_dq);
    check("q6", q6, exp_q6);
    v6 = '0;
    @(posedge clk); @(negedge clk);
    check("done6_drop", done6_valid, 0);
  endtask

  typedef struct {
    logic [3:0] valid;
    logic [1:0] op;
    logic [2:0] idx;
    logic [1:0] exp_id;
    logic [7:0] exp_q;
    logic       exp_dq;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int w;
    logic [1:0] gid;
    logic gdq;
    int exp_seq[5];

    tbl[0] = '{4'b0001, SET,  3'd3, 2'd0, 8'h08, 1'b1};
    tbl[1] = '{4'b0010, TOG,  3'd3, 2'd1, 8'h00, 1'b0};
    tbl[2] = '{4'b0010, TOG,  3'd3, 2'd1, 8'h08, 1'b1};
    tbl[3] = '{4'b0100, RST,  3'd3, 2'd2, 8'h00, 1'b0};
    tbl[4] = '{4'b1000, SET,  3'd7, 2'd3, 8'h80, 1'b1};
    tbl[5] = '{4'b0001, HOLD, 3'd7, 2'd0, 8'h80, 1'b1};
    tbl[6] = '{4'b0001, SET,  3'd0, 2'd0, 8'h81, 1'b1};
    tbl[7] = '{4'b0100, TOG,  3'd0, 2'd2, 8'h80, 1'b0};

    // reset, including a request held during reset
    reset = 1'b0;
    v6 = '0; op6 = '0; idx6 = '0;
    clear_all();
    p_valid[0] = 1'b1;
    p_op[0] = SET;
    drive();
    repeat (2) @(negedge clk);
    #1;
    check("ready_in_reset", req_ready, 0);
    check("done_in_reset", done_valid, 0);
    clear_all();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst_q", q, 8'h00);
    check("rst_ready", req_ready, 0);
    check("rst_done", done_valid, 0);
    check("rst_state", dbg_state, 0);
    check("rst_done_id", done_id, 0);

    // directed table
    for (int i = 0; i < 8; i++) begin
      for (int r = 0; r < NREQ; r++) begin
        p_valid[r] = tbl[i].valid[r];
        p_op[r]    = tbl[i].op;
        p_idx[r]   = tbl[i].idx;
      end
      run_slot(w, gid, gdq);
      check("tbl_id", gid, tbl[i].exp_id);
      check("tbl_q", q, tbl[i].exp_q);
      check("tbl_dq", gdq, tbl[i].exp_dq);
      for (int r = 0; r < NREQ; r++) p_valid[r] = 1'b0;
    end

    // reset during APPLY discards the command
    p_valid[0] = 1'b1;
    p_op[0] = SET;
    p_idx[0] = 3'd5;
    drive();
    @(posedge clk); @(negedge clk);
    check("mid_state_apply", dbg_state, 1);
    reset = 1'b0;
    #1;
    check("mid_q", q, 8'h00);
    check("mid_done", done_valid, 0);
    check("mid_ready", req_ready, 0);
    clear_all();
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); @(negedge clk);
      check("mid_post_done", done_valid, 0);
      check("mid_post_state", dbg_state, 0);
      check("mid_post_q", q, 8'h00);
    end

    // all requesters valid continuously with holds
    do_reset();
`ifdef JK_ARB_RR_EN
    exp_seq = '{0, 1, 2, 3, 0};
`else
    exp_seq = '{0, 0, 0, 0, 0};
`endif
    for (int r = 0; r < NREQ; r++) begin
      p_valid[r] = 1'b1;
      p_op[r] = HOLD;
      p_idx[r] = 3'(r);
    end
    for (int k = 0; k < 5; k++) begin
      run_slot(w, gid, gdq);
      check("rr_order", gid, 2'(exp_seq[k]));
    end

    // out-of-range index on a 6-flop bank
    do_reset();
    slot6(3'd7, 1'b1, 1'b0, 6'h00);
    slot6(3'd5, 1'b0, 1'b1, 6'h20);
    slot6(3'd6, 1'b1, 1'b0, 6'h20);

    // randomized traffic against the model
    do_reset();
    for (int n = 0; n < 60; n++) begin
      for (int r = 0; r < NREQ; r++) begin
        if (!p_valid[r] && $urandom_range(0, 1) == 1) begin
          p_valid[r] = 1'b1;
          p_op[r]    = 2'($urandom_range(0, 3));
          p_idx[r]   = 3'($urandom_range(0, NFF - 1));
        end
      end
      run_slot(w, gid, gdq);
      if (w >= 0) p_valid[w] = 1'b0;
    end
    check("final_q", q, model_q_vec());
    check("exp_q_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
